// File: rtl/cube_infer_scheduler.sv
// Round-robin scheduler that shares one cube_data_buffer and network pipeline between
// two requesters. It loads the cube, starts the network, bounds the wait, and returns a tagged result.
module cube_infer_scheduler #(
  parameter int RES_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [119:0]     req0_cube,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [119:0]     req1_cube,
  output logic             req1_ready,
  output logic             buf_load,
  output logic [119:0]     buf_d,
  output logic             net_start,
  input  logic             net_done,
  input  logic [RES_W-1:0] net_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [RES_W-1:0] res_data,
  output logic             res_timeout,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both high.
  // The producer holds valid and its payload until then. Ready never depends on
  // anything other than the current state and the current valids.

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [119:0]       buf_d_q, buf_d_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               res_id_q, res_id_d;
  logic               res_timeout_q, res_timeout_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant;
  logic               accept;

  // On a tie, the port that did not win last time gets the grant.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end
    accept = (state_q == S_IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  always_comb begin
    state_d       = state_q;
    buf_d_d       = buf_d_q;
    res_data_d    = res_data_q;
    res_id_d      = res_id_q;
    res_timeout_d = res_timeout_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          buf_d_d      = grant ? req1_cube : req0_cube;
          res_id_d     = grant;
          last_grant_d = grant;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving on the limit cycle still counts as a real result.
        cnt_d = cnt_q + CNT_W'(1);
        if (net_done) begin
          res_data_d    = net_result;
          res_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      buf_d_q       <= '0;
      res_data_q    <= '0;
      res_id_q      <= 1'b0;
      res_timeout_q <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      buf_d_q       <= buf_d_d;
      res_data_q    <= res_data_d;
      res_id_q      <= res_id_d;
      res_timeout_q <= res_timeout_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
    end
  end

  // Strobes decode straight from the state register, so reset clears them immediately.
  assign buf_load    = (state_q == S_LOAD);
  assign net_start   = (state_q == S_START);
  assign res_valid   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign buf_d       = buf_d_q;
  assign res_id      = res_id_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/cube_infer_scheduler.md
# cube_infer_scheduler

Shares one cube_data_buffer + network inference pipeline between two requesters (port 0: host input, port 1: search engine). Arbitrates round-robin, captures the winning 120-bit packed cube state, pulses the buffer load, starts the network, waits for completion with a timeout guard, and returns the result tagged with the requester ID. Sits between the request sources and the cube_data_buffer/network datapath; sole driver of the buffer's `load` and `d`.

## Interface
- `RES_W`, 8: width of network result
- `TIMEOUT`, 1023: max cycles spent in WAIT before abort (≥1)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_cube` / `req1_cube`  in  120  packed cube state (corner pos, corner dir, edge pos, edge dir)
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle
- `buf_load`  out  1  load strobe to cube_data_buffer
- `buf_d`  out  120  cube data to cube_data_buffer
- `net_start`  out  1  one-cycle start pulse to network
- `net_done`  in  1  network result valid (single-cycle pulse)
- `net_result`  in  RES_W  network result
- `res_valid`  out  1  response available
- `res_ready`  in  1  response consumer ready
- `res_id`  out  1  requester that owns the response
- `res_data`  out  RES_W  result (0 on timeout)
- `res_timeout`  out  1  response produced by timeout
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, START, WAIT, RESP; registered state, Moore outputs except `reqN_ready`.
- IDLE: grant chosen from valids; priority to the requester not granted last (`last_grant`). Only one valid → it wins. `reqN_ready` = (state==IDLE) & grant==N, combinational; at most one high. On accept: latch cube into `buf_d`, latch `res_id`, set `last_grant`, → LOAD.
- LOAD: `buf_load`=1 for exactly one cycle → START.
- START: `net_start`=1 for exactly one cycle; clear wait counter → WAIT.
- WAIT: counter increments each cycle. `net_done`=1 → latch `net_result` to `res_data`, `res_timeout`=0, → RESP. Counter reaches TIMEOUT without `net_done` → `res_data`=0, `res_timeout`=1, → RESP. `net_done` on the same cycle as the limit: done wins.
- RESP: `res_valid`=1, outputs stable until `res_ready`; handshake cycle → IDLE. No new request accepted before return to IDLE.
- `net_done` outside WAIT ignored. Valids deasserting while not granted: no effect (no state held per requester).
- Reset values: state IDLE, all strobes/valids 0, `buf_d`=0, `res_data`=0, `res_id`=0, `res_timeout`=0, counter 0, `last_grant`=1 (port 0 wins first tie).
- Reset mid-operation: immediate return to IDLE, in-flight request dropped, no response emitted; `buf_load`/`net_start` deassert asynchronously.

## Timing
- Accept at edge of cycle 0 (IDLE, valid & ready). `buf_load` high cycle 1; buffer `q` updated at end of cycle 1. `net_start` high cycle 2. Earliest accepted `net_done` cycle 3.
- `net_done` in cycle k → `res_valid` from cycle k+1.
- Timeout: `res_valid` rises TIMEOUT+1 cycles after the `net_start` cycle.
- `res_valid`&`res_ready` in cycle r → IDLE in r+1; next accept possible in r+1. Minimum request-to-request spacing: 5 cycles (done in cycle 3, response taken in cycle 4).
- `busy` high from cycle 1 through the RESP handshake cycle.

## Test plan
- Single req0, cube 120'h0123…ABC, `net_done` cycle 3 with result 8'h5A → `buf_load` cycle 1 with `buf_d`=cube, `net_start` cycle 2, `res_valid` cycle 4, `res_id`=0, `res_data`=8'h5A, `res_timeout`=0.
- Both valid continuously for 4 transactions → grant order 0,1,0,1; never both `reqN_ready` high.
- Never assert `net_done`, TIMEOUT=15 → `res_valid` 16 cycles after `net_start`, `res_timeout`=1, `res_data`=0.
- `res_ready` held low 10 cycles in RESP → `res_valid`/`res_id`/`res_data` stable; new req1 not accepted until after handshake.
- Spurious `net_done` during IDLE/LOAD/START → ignored; `rst_n` pulsed low during WAIT → all outputs 0 asynchronously, no response, next request serviced normally with port 0 priority.
